// File: rtl/selfcheck_pkg.sv
// Shared types and width helpers for the built-in self-test sequencer.
// The state enum is exported so benches and board logic can decode the debug state port.
package selfcheck_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        APPLY = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Address width for a ROM of n words; a single-word ROM still gets one address bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the value n itself (up to n failing vectors).
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Divides the clock into a one-clock tick pulse every 2**TICK_LOG2 clocks.
// With TICK_LOG2 = 0 the tick is permanently high.
module tick_gen #(
    parameter int TICK_LOG2 = 2
) (
    input  logic CLOCK_50,
    input  logic resetn,
    output logic tick
);

    generate
        if (TICK_LOG2 == 0) begin : g_every_clock
            assign tick = 1'b1;
        end else begin : g_divider
            logic [TICK_LOG2-1:0] cnt;

            always_ff @(posedge CLOCK_50 or negedge resetn) begin
                if (!resetn) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + TICK_LOG2'(1);
                end
            end

            assign tick = &cnt;
        end
    endgenerate

endmodule

// File: rtl/selfcheck_sequencer.sv
// Walks the stimulus and golden ROMs, drives a combinational DUT and tallies mismatches.
// Reports pass/fail, the failure count and the first failing vector index.
module selfcheck_sequencer
    import selfcheck_pkg::*;
#(
    parameter int INP_W     = 4,
    parameter int OUTP_W    = 4,
    parameter int N_TV      = 16,
    parameter int TICK_LOG2 = 2,
    localparam int AW       = addr_w(N_TV),
    localparam int CW       = cnt_w(N_TV)
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              start,
    output logic [AW-1:0]     tv_addr,
    input  logic [INP_W-1:0]  inp_rom_data,
    input  logic [OUTP_W-1:0] outp_rom_data,
    output logic [INP_W-1:0]  dut_inp,
    input  logic [OUTP_W-1:0] dut_outp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CW-1:0]     fail_count,
    output logic [AW-1:0]     first_fail_idx,
    output logic              first_fail_valid,
    output state_t            state_dbg
);

    state_t            state;
    state_t            state_nxt;
    logic              tick;
    logic [OUTP_W-1:0] golden;
    logic              accept;
    logic              mismatch;
    logic              last_vec;

    tick_gen #(
        .TICK_LOG2(TICK_LOG2)
    ) u_tick_gen (
        .CLOCK_50(CLOCK_50),
        .resetn  (resetn),
        .tick    (tick)
    );

    // start is a level sampled every clock; it only takes effect while idle or finished,
    // and it is accepted regardless of tick so a run begins on the very next clock.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign mismatch = (dut_outp != golden);
    assign last_vec = (tv_addr == AW'(N_TV - 1));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (tick)  state_nxt = APPLY;
            APPLY:   if (tick)  state_nxt = CHECK;
            CHECK:   if (tick)  state_nxt = last_vec ? DONE : FETCH;
            DONE:    if (start) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        state_dbg = state;
        case (state)
            FETCH, APPLY, CHECK: busy = 1'b1;
            DONE: begin
                done = 1'b1;
                pass = (fail_count == '0);
            end
            default: ;
        endcase
    end

    // FETCH holds the address for at least one clock, so the ROM words seen in APPLY
    // always belong to the current tv_addr.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tv_addr          <= '0;
            dut_inp          <= '0;
            golden           <= '0;
            fail_count       <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else if (accept) begin
            tv_addr          <= '0;
            fail_count       <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else if (tick) begin
            case (state)
                APPLY: begin
                    dut_inp <= inp_rom_data;
                    golden  <= outp_rom_data;
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_count <= fail_count + CW'(1);
                        if (!first_fail_valid) begin
                            first_fail_idx   <= tv_addr;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (!last_vec) begin
                        tv_addr <= tv_addr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_selfcheck_sequencer.sv
// Bench for selfcheck_sequencer: ROMs and a prefix-XOR DUT live here, results are
// predicted from the list of vectors whose DUT response differs from the golden word.
module tb_selfcheck_sequencer;
    import selfcheck_pkg::*;

    localparam int N_TV = 16;
    localparam int W    = 4;
    localparam int AW   = 4;
    localparam int CW   = 5;

    // clock / reset
    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] inp_rom  [N_TV];
    logic [W-1:0] gold_rom [N_TV];
    logic         dut_stuck = 1'b0;
    logic [7:0]   exp_q[$];

    // instance a: TICK_LOG2 = 0
    logic         start_a = 1'b0;
    logic [AW-1:0] addr_a, ffi_a;
    logic [W-1:0] irom_a, grom_a, dinp_a, doutp_a;
    logic         busy_a, done_a, pass_a, ffv_a;
    logic [CW-1:0] fc_a;
    state_t       st_a;

    // instance b: TICK_LOG2 = 2
    logic         start_b = 1'b0;
    logic [AW-1:0] addr_b, ffi_b;
    logic [W-1:0] irom_b, grom_b, dinp_b, doutp_b;
    logic         busy_b, done_b, pass_b, ffv_b;
    logic [CW-1:0] fc_b;
    state_t       st_b;

    function automatic logic [W-1:0] pxor(input logic [W-1:0] a);
        logic [W-1:0] o;
        o[W-1] = a[W-1];
        for (int i = W - 2; i >= 0; i--) o[i] = o[i+1] ^ a[i];
        return o;
    endfunction

    always @(posedge CLOCK_50) begin
        irom_a <= inp_rom[addr_a];
        grom_a <= gold_rom[addr_a];
        irom_b <= inp_rom[addr_b];
        grom_b <= gold_rom[addr_b];
    end

    always_comb begin
        doutp_a = dut_stuck ? '0 : pxor(dinp_a);
        doutp_b = pxor(dinp_b);
    end

    selfcheck_sequencer #(.INP_W(W), .OUTP_W(W), .N_TV(N_TV), .TICK_LOG2(0)) u_dut_a (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start_a), .tv_addr(addr_a),
        .inp_rom_data(irom_a), .outp_rom_data(grom_a), .dut_inp(dinp_a), .dut_outp(doutp_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a),
        .first_fail_idx(ffi_a), .first_fail_valid(ffv_a), .state_dbg(st_a)
    );

    selfcheck_sequencer #(.INP_W(W), .OUTP_W(W), .N_TV(N_TV), .TICK_LOG2(2)) u_dut_b (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start_b), .tv_addr(addr_b),
        .inp_rom_data(irom_b), .outp_rom_data(grom_b), .dut_inp(dinp_b), .dut_outp(doutp_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b),
        .first_fail_idx(ffi_b), .first_fail_valid(ffv_b), .state_dbg(st_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: list of failing vector indices for the current ROMs and DUT
    task automatic build_expect(input bit stuck, output int exp_fc, output int exp_ffi,
                                output int exp_ffv);
        logic [W-1:0] resp;
        exp_q.delete();
        for (int i = 0; i < N_TV; i++) begin
            resp = stuck ? '0 : pxor(inp_rom[i]);
            if (resp != gold_rom[i]) exp_q.push_back(8'(i));
        end
        exp_fc  = exp_q.size();
        exp_ffv = (exp_q.size() > 0) ? 1 : 0;
        exp_ffi = (exp_q.size() > 0) ? int'(exp_q[0]) : 0;
    endtask

    task automatic fill_rom(input bit random_inp);
        for (int i = 0; i < N_TV; i++) begin
            inp_rom[i]  = random_inp ? W'($urandom_range(0, 15)) : W'(i);
            gold_rom[i] = pxor(inp_rom[i]);
        end
    endtask

    task automatic wait_done_a(output int cycles);
        cycles = 0;
        while (!done_a && cycles < 400) begin
            @(negedge CLOCK_50);
            cycles++;
        end
    endtask

    task automatic check_result_a(input string tag);
        int exp_fc, exp_ffi, exp_ffv;
        build_expect(dut_stuck, exp_fc, exp_ffi, exp_ffv);
        chk({tag, ".done"}, done_a, 1);
        chk({tag, ".busy"}, busy_a, 0);
        chk({tag, ".pass"}, pass_a, (exp_fc == 0) ? 1 : 0);
        chk({tag, ".fail_count"}, fc_a, exp_fc);
        chk({tag, ".first_fail_idx"}, ffi_a, exp_ffi);
        chk({tag, ".first_fail_valid"}, ffv_a, exp_ffv);
    endtask

    // driver: full run on instance a, entered and left on a falling edge
    task automatic run_a(input string tag);
        int cycles;
        start_a = 1'b1;
        @(negedge CLOCK_50);
        start_a = 1'b0;
        chk({tag, ".busy_after_start"}, busy_a, 1);
        chk({tag, ".done_cleared"}, done_a, 0);
        chk({tag, ".fail_count_cleared"}, fc_a, 0);
        wait_done_a(cycles);
        chk({tag, ".latency"}, cycles, 48);
        check_result_a(tag);
    endtask

    // tick-alignment monitor for instance b
    logic [1:0] ref_div;
    state_t     prev_b = IDLE;
    bit         mon_on = 1'b0;

    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) ref_div <= '0;
        else         ref_div <= ref_div + 2'd1;
    end

    always @(negedge CLOCK_50) begin
        if (mon_on && (st_b != prev_b) && (prev_b inside {FETCH, APPLY, CHECK}))
            chk("t6.tick_aligned", 32'(ref_div), 0);
        prev_b = st_b;
    end

    initial begin
        int cycles, guard, exp_fc, exp_ffi, exp_ffv;

        fill_rom(1'b0);
        #2 resetn = 1'b0;
        #2;
        chk("reset.state", st_a, IDLE);
        chk("reset.busy", busy_a, 0);
        chk("reset.done", done_a, 0);
        chk("reset.pass", pass_a, 0);
        chk("reset.fail_count", fc_a, 0);
        chk("reset.tv_addr", addr_a, 0);
        chk("reset.first_fail_valid", ffv_a, 0);
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);

        // 1: clean pass
        run_a("t1");

        // 2: corrupted golden word
        gold_rom[5] = gold_rom[5] ^ 4'h6;
        run_a("t2");

        // 3: stuck-at-0 DUT
        fill_rom(1'b0);
        dut_stuck = 1'b1;
        run_a("t3");
        dut_stuck = 1'b0;

        // 4: reset mid-run
        gold_rom[2] = gold_rom[2] ^ 4'h1;
        start_a = 1'b1;
        @(negedge CLOCK_50);
        start_a = 1'b0;
        guard = 0;
        while (addr_a != 4'd7 && guard < 200) begin
            @(negedge CLOCK_50);
            guard++;
        end
        chk("t4.reached_addr7", addr_a, 7);
        resetn = 1'b0;
        #1;
        chk("t4.state", st_a, IDLE);
        chk("t4.tv_addr", addr_a, 0);
        chk("t4.dut_inp", dinp_a, 0);
        chk("t4.busy", busy_a, 0);
        chk("t4.fail_count", fc_a, 0);
        chk("t4.first_fail_valid", ffv_a, 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        fill_rom(1'b0);
        run_a("t4.rerun");

        // 5: start during CHECK of vector 3 is ignored; start in DONE reruns
        gold_rom[10] = gold_rom[10] ^ 4'h8;
        start_a = 1'b1;
        @(negedge CLOCK_50);
        start_a = 1'b0;
        guard = 0;
        while (!(st_a == CHECK && addr_a == 4'd3) && guard < 200) begin
            @(negedge CLOCK_50);
            guard++;
        end
        start_a = 1'b1;
        @(negedge CLOCK_50);
        start_a = 1'b0;
        chk("t5.addr_continues", addr_a, 4);
        chk("t5.state_fetch", st_a, FETCH);
        wait_done_a(cycles);
        check_result_a("t5.first");
        fill_rom(1'b0);
        gold_rom[0]        = gold_rom[0] ^ 4'h2;
        gold_rom[N_TV - 1] = gold_rom[N_TV - 1] ^ 4'h4;
        run_a("t5.rerun");

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            fill_rom(1'b1);
            for (int k = $urandom_range(0, 4); k > 0; k--)
                gold_rom[$urandom_range(0, N_TV - 1)] ^= W'($urandom_range(1, 15));
            dut_stuck = ($urandom_range(0, 3) == 0);
            run_a($sformatf("rand%0d", r));
        end
        dut_stuck = 1'b0;

        // 6: divided tick on instance b
        fill_rom(1'b0);
        build_expect(1'b0, exp_fc, exp_ffi, exp_ffv);
        mon_on  = 1'b1;
        start_b = 1'b1;
        @(negedge CLOCK_50);
        start_b = 1'b0;
        chk("t6.busy_after_start", busy_b, 1);
        cycles = 0;
        while (!done_b && cycles < 400) begin
            @(negedge CLOCK_50);
            cycles++;
        end
        mon_on = 1'b0;
        chk("t6.latency_in_range", (cycles >= 189 && cycles <= 196) ? 1 : 0, 1);
        chk("t6.done", done_b, 1);
        chk("t6.pass", pass_b, (exp_fc == 0) ? 1 : 0);
        chk("t6.fail_count", fc_b, exp_fc);
        chk("t6.first_fail_valid", ffv_b, exp_ffv);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
